tt_checker: RTL

TT_CHECKER -- requirements
Module: tt_checker

---
 rtl/tt_pkg.sv | 6 +
 rtl/tt_checker.sv | 85 ++++++++
 2 files changed

// File: rtl/tt_pkg.sv
// tt_pkg: shared FSM encoding and table dimensions for the truth-table checker
package tt_pkg;
    localparam int MAX_ROWS = 16;
    localparam int IDX_W = 4;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} stateT;
endpackage

// File: rtl/tt_checker.sv
// tt_checker: steps a combinational DUT through every input row and compares its response to a latched truth table
module tt_checker
    import tt_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [MAX_ROWS-1:0] expected,
    input  logic                dut_y,
    output logic [IDX_W-1:0]    vec_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [MAX_ROWS-1:0] captured,
    output logic [IDX_W-1:0]    fail_idx,
    output logic [4:0]          fail_cnt
);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'((1 << N_IN) - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    stateT state;
    logic [3:0] settleCnt;
    logic [IDX_W-1:0] rowIdx;
    logic [MAX_ROWS-1:0] expLatch;
    logic mismatch;
    assign mismatch = dut_y != expLatch[rowIdx];
    // run sequencer: hold each vector SETTLE cycles, sample once, and fold the final row into pass on the way to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            settleCnt <= '0;
            rowIdx <= '0;
            expLatch <= '0;
            vec_out <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            captured <= '0;
            fail_idx <= '0;
            fail_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= DRIVE;
                    rowIdx <= '0;
                    vec_out <= '0;
                    settleCnt <= '0;
                    captured <= '0;
                    fail_cnt <= '0;
                    fail_idx <= '0;
                    pass <= 1'b0;
                    expLatch <= expected;
                    busy <= 1'b1;
                end
                DRIVE: begin
                    settleCnt <= settleCnt + 4'd1;
                    if (settleCnt == SETTLE_LAST) state <= SAMPLE;
                end
                SAMPLE: begin
                    captured[rowIdx] <= dut_y;
                    if (mismatch) fail_cnt <= fail_cnt + 5'd1;
                    if (mismatch && fail_cnt == 5'd0) fail_idx <= rowIdx;
                    if (rowIdx == LAST_ROW) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= fail_cnt == 5'd0 && !mismatch;
                    end else begin
                        state <= DRIVE;
                        rowIdx <= rowIdx + 1'b1;
                        vec_out <= vec_out + 1'b1;
                        settleCnt <= '0;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
